// File: rtl/rx_block_packer.sv
// Packs UART receiver bytes into BYTES-wide blocks, first byte in the most significant slot.
// A byte lands 2 edges after rx_flag is sampled high; bytes arriving while a block is held are dropped.
module rx_block_packer #(
  parameter int BYTES   = 16,
  parameter int TIMEOUT = 4_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_flag,
  output logic [8*BYTES-1:0]         block_data,
  output logic                       block_valid,
  input  logic                       block_ready,
  output logic [$clog2(BYTES+1)-1:0] byte_count,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic                       timeout
);
  localparam int BW = $clog2(BYTES+1);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [BW-1:0] LAST      = BW'(BYTES-1);
  localparam logic [CW-1:0] IDLE_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT-1) : '0;

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state, state_nxt;
  logic          s1, s2, s3, strobe;
  logic          store, drop, fire;
  logic [CW-1:0] idle;

  // Flops preset high so a receiver idling high cannot fake a rising edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {s1, s2, s3} <= 3'b111;
    else     {s1, s2, s3} <= {rx_flag, s1, s2};
  end

  assign strobe = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store     = 1'b0;
    drop      = 1'b0;
    fire      = 1'b0;
    case (state)
      FILL: begin
        if (strobe) begin
          store = 1'b1;
          if (byte_count == LAST) state_nxt = HOLD;
        end else if (TIMEOUT > 0 && byte_count != '0 && idle == IDLE_LAST) begin
          fire = 1'b1;
        end
      end
      HOLD: begin
        // byte_count is 0 here, so a strobe on the handshake cycle lands in slot 0.
        if (block_ready) begin
          state_nxt = FILL;
          store     = strobe;
        end else begin
          drop = strobe;
        end
      end
    endcase
  end

  assign block_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_data <= '0;
      byte_count <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      idle       <= '0;
    end else begin
      timeout <= fire;
      overrun <= (overrun & ~overrun_clr) | drop;
      if (store) begin
        block_data[8*(BYTES-1-int'(byte_count)) +: 8] <= rx_data;
        byte_count <= (byte_count == LAST) ? '0 : byte_count + 1'b1;
      end else if (fire) begin
        byte_count <= '0;
      end
      if (TIMEOUT == 0 || store || fire || state == HOLD || byte_count == '0) idle <= '0;
      else                                                                      idle <= idle + 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_block_packer.sv
// Randomized scoreboard bench for rx_block_packer with a queue-based reference model.
module tb_rx_block_packer;
  localparam int BYTES = 16;
  localparam int TMO   = 50;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         rx_data;
  logic               rx_flag;
  logic [8*BYTES-1:0] block_data;
  logic               block_valid;
  logic               block_ready;
  logic [4:0]         byte_count;
  logic               overrun;
  logic               overrun_clr;
  logic               timeout;

  int total = 0;
  int bad   = 0;

  logic [8*BYTES-1:0] expq[$];
  logic [7:0]         partial[$];
  bit                 pending = 1'b0;
  bit                 ov = 1'b0;

  always #5 clk = ~clk;

  rx_block_packer #(.BYTES(BYTES), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_flag(rx_flag),
    .block_data(block_data), .block_valid(block_valid), .block_ready(block_ready),
    .byte_count(byte_count), .overrun(overrun), .overrun_clr(overrun_clr),
    .timeout(timeout)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens at the next edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    #1;
    if (!rst && block_valid && block_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block: got %0h expected none", block_data);
      end else begin
        check("block_data", block_data, expq.pop_front());
      end
    end
  end

  task automatic model_push_block();
    logic [8*BYTES-1:0] blk;
    blk = '0;
    for (int i = 0; i < BYTES; i++) blk[8*(BYTES-1-i) +: 8] = partial[i];
    expq.push_back(blk);
    partial.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    bit done_now;
    bit dropped;
    done_now = 1'b0;
    @(negedge clk);
    block_ready = rdy;
    rx_flag     = 1'b0;
    if (rdy) pending = 1'b0;
    repeat (2) @(negedge clk);
    rx_data = b;
    rx_flag = 1'b1;
    repeat (2) @(negedge clk);
    check("count_before_store", 128'(byte_count), 128'(partial.size()));
    @(negedge clk);
    dropped = pending;
    if (pending) begin
      ov = 1'b1;
    end else begin
      partial.push_back(b);
      if (partial.size() == BYTES) begin
        model_push_block();
        done_now = 1'b1;
        pending  = !rdy;
      end
    end
    check("byte_count", 128'(byte_count), 128'(partial.size()));
    check("overrun", 128'(overrun), 128'(ov));
    check("block_valid", 128'(block_valid), 128'(done_now || dropped));
  endtask

  // Strobe timed to land on the same edge as the handshake of a held block.
  task automatic send_coincident(input logic [7:0] b);
    @(negedge clk);
    block_ready = 1'b0;
    rx_flag     = 1'b0;
    repeat (2) @(negedge clk);
    rx_data = b;
    rx_flag = 1'b1;
    repeat (2) @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    pending = 1'b0;
    partial.delete();
    partial.push_back(b);
    check("coincide_count", 128'(byte_count), 128'd1);
    check("coincide_overrun", 128'(overrun), 128'(ov));
    check("coincide_valid", 128'(block_valid), 128'd0);
  endtask

  task automatic clear_ov();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    ov = 1'b0;
    check("overrun_clr", 128'(overrun), 128'd0);
  endtask

  initial begin
    rst         = 1'b1;
    rx_flag     = 1'b1;
    rx_data     = 8'h00;
    block_ready = 1'b0;
    overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(block_valid), 128'd0);
    check("rst_count", 128'(byte_count), 128'd0);
    check("rst_data", block_data, 128'd0);
    check("rst_overrun", 128'(overrun), 128'd0);
    check("rst_timeout", 128'(timeout), 128'd0);
    rst = 1'b0;

    // Flag held high through reset release must not produce a strobe.
    repeat (5) @(negedge clk);
    check("no_strobe_count", 128'(byte_count), 128'd0);
    check("no_strobe_valid", 128'(block_valid), 128'd0);

    // Partial block of 5 bytes, then idle until the timeout discards it.
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    for (int j = 1; j <= 51; j++) begin
      @(negedge clk);
      if (j == 49) begin
        check("timeout_early", 128'(timeout), 128'd0);
        check("count_before_timeout", 128'(byte_count), 128'd5);
      end else if (j == 50) begin
        check("timeout_pulse", 128'(timeout), 128'd1);
        check("count_after_timeout", 128'(byte_count), 128'd0);
      end else if (j == 51) begin
        check("timeout_one_cycle", 128'(timeout), 128'd0);
      end
    end
    partial.delete();

    // Ordered block with ready held high: valid must pulse exactly one cycle.
    for (int i = 0; i < BYTES; i++) send_byte(8'(i), 1'b1);
    @(negedge clk);
    check("valid_pulse_end", 128'(block_valid), 128'd0);
    check("count_after_block", 128'(byte_count), 128'd0);

    // Backpressure: a 17th byte is dropped and the held block is untouched.
    for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'h55, 1'b0);
    check("held_block_data", block_data, expq[$]);
    send_byte(8'h77, 1'b1);
    for (int i = 1; i < BYTES; i++) send_byte(8'($urandom), 1'b1);
    clear_ov();

    // Strobe on the handshake cycle.
    for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), 1'b0);
    send_coincident(8'hC3);
    for (int i = 1; i < BYTES; i++) send_byte(8'($urandom), 1'b1);

    // Random traffic with random backpressure and occasional overrun clears.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 15) == 0) clear_ov();
      send_byte(8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Reset while a block is held: valid must drop without a clock edge.
    for (int n = 0; n < 40 && !pending; n++) send_byte(8'($urandom), 1'b0);
    check("pre_reset_valid", 128'(block_valid), 128'(pending));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(block_valid), 128'd0);
    check("async_rst_count", 128'(byte_count), 128'd0);
    check("async_rst_data", block_data, 128'd0);
    check("async_rst_overrun", 128'(overrun), 128'd0);
    check("async_rst_timeout", 128'(timeout), 128'd0);
    if (pending) void'(expq.pop_back());
    partial.delete();
    pending = 1'b0;
    ov      = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), 1'b1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(expq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_block_packer.md
# rx_block_packer

Sits directly downstream of the UART byte receiver and packs its bytes into fixed-size blocks for the crypto core. Watches the receiver's done flag (`rx_flag`, idles high, goes low during a frame, returns high when the byte is ready) and captures `rx_data` on each rising edge. Packs `BYTES` consecutive bytes into one wide block, first byte in the most significant position. Presents the block on a valid/ready handshake, with an inter-byte timeout and an overrun indicator.

## Interface
- `BYTES`, 16: bytes per block; legal range 2..64.
- `TIMEOUT`, 4_000_000: idle clocks allowed between bytes of a partial block before it is discarded; 0 disables the timeout.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  byte from the UART receiver; stable while `rx_flag` is high after a frame.
- `rx_flag`  in  1  receiver done flag; asynchronous to `clk`, synchronised internally.
- `block_data`  out  8*BYTES  packed block; byte 0 at [8*BYTES-1 -: 8].
- `block_valid`  out  1  block available.
- `block_ready`  in  1  consumer accepts the block.
- `byte_count`  out  $clog2(BYTES+1)  bytes held in the current partial block.
- `overrun`  out  1  sticky; a byte was dropped.
- `overrun_clr`  in  1  clears `overrun`.
- `timeout`  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- Synchroniser:
  - Three flops: s1 <= `rx_flag`, s2 <= s1, s3 <= s2.
  - Byte strobe = s2 & ~s3.
  - All three flops reset to 1, because the receiver idles high. No strobe may occur out of reset.
- States: FILL and HOLD. Reset state is FILL.
- FILL:
  - On a strobe, write `rx_data` into slot `byte_count` and increment `byte_count`.
  - When the strobe writes slot BYTES-1, go to HOLD, set `block_valid`=1 and set `byte_count`=0.
- HOLD:
  - `block_data` and `block_valid` hold until `block_valid` & `block_ready`.
  - On that handshake, return to FILL.
  - A strobe while in HOLD, except on the handshake cycle, drops the byte and sets `overrun`.
- Strobe on the handshake cycle: the byte is stored as slot 0 of the next block; `byte_count` becomes 1 and no overrun is flagged.
- Storage: the working register is `block_data` itself. Unwritten slots keep stale contents; consumers use `block_valid` only.
- Timeout:
  - An idle counter runs in FILL while `byte_count`≠0. It clears on every strobe.
  - When it reaches `TIMEOUT`: set `byte_count`=0, pulse `timeout` for 1 cycle and clear the counter.
  - A strobe in that same cycle wins: the byte is stored and no timeout occurs.
  - With `TIMEOUT`=0 the counter never fires.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1.
- Reset mid-operation:
  - Any partial block is lost.
  - `block_valid` drops immediately, because the reset is asynchronous.

## Timing
- Reset values: `block_data`=0, `block_valid`=0, `byte_count`=0, `overrun`=0, `timeout`=0, state FILL, idle counter 0.
- `rx_flag` first sampled high at clock edge k:
  - The byte is stored and `byte_count` is updated at edge k+2.
  - For the last slot, `block_valid` rises at edge k+2.
- Handshake: `block_valid` falls at the edge following the cycle where both `block_valid` and `block_ready` are high. `block_ready` may be held high permanently.
- `block_valid` must not depend combinationally on `block_ready`.
- The timeout pulse is registered and fires at the edge where the counter would equal `TIMEOUT`.
- Minimum byte spacing: one strobe per 3 clocks. UART frames are far slower than this.

## Test plan
- Reset, then 16 frames 0x00..0x0F with `block_ready`=1:
  - `block_valid` pulses for 1 cycle.
  - `block_data`=0x000102…0F.
  - `byte_count` returns to 0.
- Reset while `rx_flag`=1:
  - No strobe occurs and `byte_count` stays 0.
  - A later single frame 0xA5 gives `byte_count`=1 exactly 2 edges after `rx_flag` is sampled high.
- Backpressure with `block_ready`=0 after 16 bytes:
  - A 17th byte 0x55 sets `overrun`=1, and `block_data` is unchanged.
  - Asserting `block_ready` then lets the 18th byte land in slot 0.
- Strobe coinciding with the handshake cycle: byte 0xC3 becomes slot 0 of the next block, `byte_count`=1, `overrun`=0.
- `TIMEOUT`=50, 5 bytes, then idle:
  - `timeout` pulses once, 50 clocks after the last strobe, and `byte_count`=0.
  - The next 16 bytes form a clean block.
- Assert `rst` while `block_valid`=1: `block_valid` drops without waiting for a clock edge, and all outputs return to their reset values.
